// File: rtl/sumador_seq.sv
// Lane-serial vector add over one shared W-bit sumador; done at cycle LANES+2 after start, no backpressure (start ignored unless idle).
// Optional SUMADOR_SEQ_OVF_EN adds a sticky per-operation carry-out flag on port ovf.
module sumador_seq #(
    parameter int LANES = 4,
    parameter int W     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LANES*W-1:0]   a_vec,
    input  logic [LANES*W-1:0]   b_vec,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W-1:0]         add_c,
    output logic                 busy,
    output logic                 done,
    output logic [LANES*W-1:0]   c_vec
`ifdef SUMADOR_SEQ_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [LANES*W-1:0] op_a;
    logic [LANES*W-1:0] op_b;
    logic [LANES*W-1:0] work;
    logic [LANES*W-1:0] work_nxt;
    logic               last;

    assign last = (cnt == LAST_LANE);
    assign busy = (state == S_LOAD) || (state == S_RUN);
    assign done = (state == S_DONE);

    // Operands go straight from the capture registers to the shared adder.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state == S_RUN) begin
            add_a = op_a[cnt*W +: W];
            add_b = op_b[cnt*W +: W];
        end
    end

    always_comb begin
        work_nxt = work;
        work_nxt[cnt*W +: W] = add_c;
    end

    // c_vec is loaded on the edge entering DONE so it is already valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            c_vec <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a  <= a_vec;
                        op_b  <= b_vec;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    work <= work_nxt;
                    if (last) begin
                        c_vec <= work_nxt;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SUMADOR_SEQ_OVF_EN
    logic [W:0] lane_sum;

    assign lane_sum = {1'b0, add_a} + {1'b0, add_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == S_LOAD) begin
            ovf <= 1'b0;
        end else if ((state == S_RUN) && lane_sum[W]) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule
